// File: rtl/timestamp_rr_pkg.sv
// Shared types and helpers for the timestamp live-value-table RAM: entry states,
// wrap-safe timestamp ordering and the bank-winner resolution rule.
package timestamp_rr_pkg;

  localparam int unsigned MAX_BANKS   = 16;
  localparam int unsigned MAX_TS_BITS = 32;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    STALE   = 2'd1,
    FRESH   = 2'd2
  } entry_state_e;

  typedef enum logic {
    SCAN = 1'b0,
    WRAP = 1'b1
  } scrub_state_e;

  typedef struct packed {
    entry_state_e           state;
    logic [MAX_TS_BITS-1:0] ts;
  } entry_t;

  typedef entry_t [MAX_BANKS-1:0] entry_vec_t;

  function automatic int unsigned bit_count(input int unsigned v);
    int unsigned n;
    n = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((v >> i) != 0) n = i + 1;
    end
    return n;
  endfunction

  // a is newer than b when their modular distance lies in the lower half-circle.
  function automatic logic newer(input logic [MAX_TS_BITS-1:0] a,
                                 input logic [MAX_TS_BITS-1:0] b,
                                 input int unsigned time_bits);
    logic [MAX_TS_BITS-1:0] mask;
    logic [MAX_TS_BITS-1:0] d;
    mask = (time_bits >= MAX_TS_BITS) ? '1 : ((32'd1 << time_bits) - 32'd1);
    d    = (a - b) & mask;
    return (d != '0) && (d < (32'd1 << (time_bits - 1)));
  endfunction

  // Newest FRESH wins (ties -> highest index), else lowest STALE, else index 0.
  function automatic int unsigned resolve(input entry_vec_t e,
                                          input int unsigned n,
                                          input int unsigned time_bits);
    logic        have_fresh;
    logic        have_stale;
    int unsigned f;
    int unsigned s;
    have_fresh = 1'b0;
    have_stale = 1'b0;
    f = 0;
    s = 0;
    for (int unsigned i = 0; i < MAX_BANKS; i++) begin
      if (i < n) begin
        if (e[i].state == FRESH) begin
          if (!have_fresh || !newer(e[f].ts, e[i].ts, time_bits)) f = i;
          have_fresh = 1'b1;
        end else if (e[i].state == STALE && !have_stale) begin
          s = i;
          have_stale = 1'b1;
        end
      end
    end
    return have_fresh ? f : s;
  endfunction

endpackage

// File: rtl/timestamp_lvt_ram_if.sv
// Write/read bus of the timestamp LVT RAM; the RAM is the slave.
interface timestamp_lvt_ram_if
  import timestamp_rr_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned INPUTS     = 4,
  parameter int unsigned OUTPUTS    = 4,
  parameter int unsigned ADDR_WIDTH = bit_count(DEPTH - 1)
);
  logic [0:INPUTS-1]                  wr;
  logic [0:INPUTS-1][ADDR_WIDTH-1:0]  wr_addr;
  logic [0:INPUTS-1][WIDTH-1:0]       wr_data;
  logic [0:OUTPUTS-1]                 rd;
  logic [0:OUTPUTS-1][ADDR_WIDTH-1:0] rd_addr;
  logic [0:OUTPUTS-1][WIDTH-1:0]      rd_data;
  logic [0:OUTPUTS-1]                 rd_valid;
  logic                               wr_collision;

  modport master (output wr, wr_addr, wr_data, rd, rd_addr,
                  input  rd_data, rd_valid, wr_collision);
  modport slave  (input  wr, wr_addr, wr_data, rd, rd_addr,
                  output rd_data, rd_valid, wr_collision);
endinterface

// File: rtl/timestamp_rr_bank.sv
// One replica data bank: single write port, OUTPUTS asynchronous read ports, no reset.
module timestamp_rr_bank #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned OUTPUTS    = 4,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                               clk,
  input  logic                               i_we,
  input  logic [ADDR_WIDTH-1:0]              i_waddr,
  input  logic [WIDTH-1:0]                   i_wdata,
  input  logic [0:OUTPUTS-1][ADDR_WIDTH-1:0] i_raddr,
  output logic [0:OUTPUTS-1][WIDTH-1:0]      o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_comb begin
    o_rdata = '0;
    for (int unsigned p = 0; p < OUTPUTS; p++) o_rdata[p] = r_mem[i_raddr[p]];
  end
endmodule

// File: rtl/timestamp_lvt_ram.sv
// Multi-port RAM: one replica bank per write port, a per-entry timestamp table picks
// the newest bank, and a background scrubber demotes old entries before they alias.
module timestamp_lvt_ram
  import timestamp_rr_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned DEPTH      = 512,
  parameter int unsigned INPUTS     = 4,
  parameter int unsigned OUTPUTS    = 4,
  parameter int unsigned TIME_BITS  = 16,
  parameter int unsigned ADDR_WIDTH = bit_count(DEPTH - 1)
) (
  input logic          clk,
  input logic          rst,
  timestamp_lvt_ram_if.slave bus
);
  localparam logic [TIME_BITS-1:0] STALE_AGE = TIME_BITS'(1) << (TIME_BITS - 2);

  if (DEPTH >= (64'd1 << (TIME_BITS - 2)) || INPUTS > MAX_BANKS ||
      TIME_BITS > MAX_TS_BITS || TIME_BITS < 3 || DEPTH < 2) begin : g_param_check
    $error("timestamp_lvt_ram: DEPTH must be below 2**(TIME_BITS-2)");
  end

  logic [TIME_BITS-1:0]            r_now;
  entry_state_e                    r_state [DEPTH][INPUTS];
  logic [TIME_BITS-1:0]            r_ts    [DEPTH][INPUTS];
  logic [ADDR_WIDTH-1:0]           r_ptr;
  scrub_state_e                    r_scrub;
  logic [0:OUTPUTS-1][WIDTH-1:0]   r_rd_data;
  logic [0:OUTPUTS-1]              r_rd_valid;
  logic                            r_wr_collision;

  logic [0:OUTPUTS-1][WIDTH-1:0]   w_bank_rdata [INPUTS];
  logic [0:OUTPUTS-1][WIDTH-1:0]   w_rd_data;
  entry_vec_t                      w_scrub_e;
  int unsigned                     w_scrub_win;
  logic                            w_wr_collision;

  for (genvar b = 0; b < INPUTS; b++) begin : g_bank
    timestamp_rr_bank #(
      .WIDTH     (WIDTH),
      .DEPTH     (DEPTH),
      .OUTPUTS   (OUTPUTS),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clk    (clk),
      .i_we   (bus.wr[b]),
      .i_waddr(bus.wr_addr[b]),
      .i_wdata(bus.wr_data[b]),
      .i_raddr(bus.rd_addr),
      .o_rdata(w_bank_rdata[b])
    );
  end

  function automatic entry_vec_t entries_at(input logic [ADDR_WIDTH-1:0] a);
    entry_vec_t e;
    e = '0;
    for (int unsigned b = 0; b < INPUTS; b++) begin
      e[b].state = r_state[a][b];
      e[b].ts    = MAX_TS_BITS'(r_ts[a][b]);
    end
    return e;
  endfunction

  always_comb begin
    entry_vec_t  e;
    int unsigned win;
    w_rd_data = '0;
    e         = '0;
    win       = 0;
    for (int unsigned p = 0; p < OUTPUTS; p++) begin
      e   = entries_at(bus.rd_addr[p]);
      win = resolve(e, INPUTS, TIME_BITS);
      for (int unsigned b = 0; b < INPUTS; b++) begin
        if (b == win && e[b].state != INVALID) w_rd_data[p] = w_bank_rdata[b][p];
      end
    end
  end

  always_comb begin
    w_scrub_e   = entries_at(r_ptr);
    w_scrub_win = resolve(w_scrub_e, INPUTS, TIME_BITS);
  end

  always_comb begin
    w_wr_collision = 1'b0;
    for (int unsigned i = 0; i < INPUTS; i++) begin
      for (int unsigned j = i + 1; j < INPUTS; j++) begin
        if (bus.wr[i] && bus.wr[j] && bus.wr_addr[i] == bus.wr_addr[j]) w_wr_collision = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < INPUTS; i++) begin
      if (bus.wr[i]) r_ts[bus.wr_addr[i]][i] <= r_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_now          <= '0;
      r_ptr          <= '0;
      r_scrub        <= SCAN;
      r_rd_valid     <= '0;
      r_rd_data      <= '0;
      r_wr_collision <= 1'b0;
      for (int unsigned d = 0; d < DEPTH; d++) begin
        for (int unsigned b = 0; b < INPUTS; b++) r_state[d][b] <= INVALID;
      end
    end else begin
      r_now <= r_now + 1'b1;
      for (int unsigned b = 0; b < INPUTS; b++) begin
        if (b != w_scrub_win) begin
          r_state[r_ptr][b] <= INVALID;
        end else if (w_scrub_e[b].state == FRESH && (r_now - r_ts[r_ptr][b]) >= STALE_AGE) begin
          r_state[r_ptr][b] <= STALE;
        end
      end
      // Later non-blocking writes win, so user writes override the scrub for their bank only.
      for (int unsigned i = 0; i < INPUTS; i++) begin
        if (bus.wr[i]) r_state[bus.wr_addr[i]][i] <= FRESH;
      end
      // WRAP is the cycle that visits DEPTH-1; it returns to SCAN at pointer 0.
      case (r_scrub)
        SCAN: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == ADDR_WIDTH'(DEPTH - 2)) r_scrub <= WRAP;
        end
        WRAP: begin
          r_ptr   <= '0;
          r_scrub <= SCAN;
        end
      endcase
      r_rd_valid     <= bus.rd;
      r_wr_collision <= w_wr_collision;
      for (int unsigned p = 0; p < OUTPUTS; p++) begin
        if (bus.rd[p]) r_rd_data[p] <= w_rd_data[p];
      end
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.wr_collision = r_wr_collision;
endmodule

// File: tb/tb_timestamp_lvt_ram.sv
// Bench for timestamp_lvt_ram: a default-size and a small fast-wrapping instance,
// each compared against a plain "last written value" memory model.
module tb_timestamp_lvt_ram;
  import timestamp_rr_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned NI = 4;
  localparam int unsigned NO = 4;
  localparam int unsigned DB = 512;
  localparam int unsigned AB = 9;
  localparam int unsigned DS = 8;
  localparam int unsigned AS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  timestamp_lvt_ram_if #(.WIDTH(W), .DEPTH(DB), .INPUTS(NI), .OUTPUTS(NO), .ADDR_WIDTH(AB)) bb ();
  timestamp_lvt_ram_if #(.WIDTH(W), .DEPTH(DS), .INPUTS(NI), .OUTPUTS(NO), .ADDR_WIDTH(AS)) bs ();

  timestamp_lvt_ram #(.WIDTH(W), .DEPTH(DB), .INPUTS(NI), .OUTPUTS(NO), .TIME_BITS(16), .ADDR_WIDTH(AB))
    dut_b (.clk(clk), .rst(rst), .bus(bb));
  timestamp_lvt_ram #(.WIDTH(W), .DEPTH(DS), .INPUTS(NI), .OUTPUTS(NO), .TIME_BITS(6), .ADDR_WIDTH(AS))
    dut_s (.clk(clk), .rst(rst), .bus(bs));

  logic [W-1:0]  mem_b [DB];
  logic [W-1:0]  mem_s [DS];
  logic [W-1:0]  exp_db [NO];
  logic [W-1:0]  exp_ds [NO];
  logic [NO-1:0] exp_vb;
  logic [NO-1:0] exp_vs;
  logic          exp_cb;
  logic          exp_cs;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < DB; a++) mem_b[a] = '0;
    for (int a = 0; a < DS; a++) mem_s[a] = '0;
    for (int p = 0; p < NO; p++) begin
      exp_db[p] = '0;
      exp_ds[p] = '0;
    end
    exp_vb = '0;
    exp_vs = '0;
    exp_cb = 1'b0;
    exp_cs = 1'b0;
  endtask

  task automatic drive_idle();
    bb.wr = '0; bb.wr_addr = '0; bb.wr_data = '0; bb.rd = '0; bb.rd_addr = '0;
    bs.wr = '0; bs.wr_addr = '0; bs.wr_data = '0; bs.rd = '0; bs.rd_addr = '0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < NI; i++) begin
      bb.wr[i]      = ($urandom_range(0, 99) < 30);
      bb.wr_addr[i] = AB'($urandom_range(0, 15));
      bb.wr_data[i] = {$urandom(), $urandom()};
      bs.wr[i]      = ($urandom_range(0, 99) < 15);
      bs.wr_addr[i] = AS'($urandom_range(0, DS - 1));
      bs.wr_data[i] = {$urandom(), $urandom()};
    end
    for (int p = 0; p < NO; p++) begin
      bb.rd[p]      = ($urandom_range(0, 99) < 60);
      bb.rd_addr[p] = AB'($urandom_range(0, 15));
      bs.rd[p]      = ($urandom_range(0, 99) < 60);
      bs.rd_addr[p] = AS'($urandom_range(0, DS - 1));
    end
  endtask

  task automatic check_outputs();
    for (int p = 0; p < NO; p++) begin
      chk($sformatf("big.rd_valid[%0d]", p), W'(bb.rd_valid[p]), W'(exp_vb[p]));
      chk($sformatf("big.rd_data[%0d]", p), bb.rd_data[p], exp_db[p]);
      chk($sformatf("small.rd_valid[%0d]", p), W'(bs.rd_valid[p]), W'(exp_vs[p]));
      chk($sformatf("small.rd_data[%0d]", p), bs.rd_data[p], exp_ds[p]);
    end
    chk("big.wr_collision", W'(bb.wr_collision), W'(exp_cb));
    chk("small.wr_collision", W'(bs.wr_collision), W'(exp_cs));
  endtask

  // Reads see memory before this cycle's writes; same-cycle writes land in port order.
  task automatic cycle();
    @(posedge clk);
    exp_cb = 1'b0;
    exp_cs = 1'b0;
    for (int p = 0; p < NO; p++) begin
      exp_vb[p] = bb.rd[p];
      if (bb.rd[p]) exp_db[p] = mem_b[bb.rd_addr[p]];
      exp_vs[p] = bs.rd[p];
      if (bs.rd[p]) exp_ds[p] = mem_s[bs.rd_addr[p]];
    end
    for (int i = 0; i < NI; i++) begin
      for (int j = i + 1; j < NI; j++) begin
        if (bb.wr[i] && bb.wr[j] && bb.wr_addr[i] == bb.wr_addr[j]) exp_cb = 1'b1;
        if (bs.wr[i] && bs.wr[j] && bs.wr_addr[i] == bs.wr_addr[j]) exp_cs = 1'b1;
      end
    end
    for (int i = 0; i < NI; i++) begin
      if (bb.wr[i]) mem_b[bb.wr_addr[i]] = bb.wr_data[i];
      if (bs.wr[i]) mem_s[bs.wr_addr[i]] = bs.wr_data[i];
    end
    #1;
    check_outputs();
  endtask

  initial begin
    drive_idle();
    model_reset();
    #12;
    check_outputs();
    chk("big.scrub_ptr_reset", W'(dut_b.r_ptr), '0);
    chk("small.scrub_ptr_reset", W'(dut_s.r_ptr), '0);
    @(negedge clk);
    rst = 1'b0;

    // Read of never-written address returns zero with valid.
    bb.rd[0] = 1'b1; bb.rd_addr[0] = AB'(5);
    cycle();
    chk("unwritten read valid", W'(bb.rd_valid[0]), W'(1));
    chk("unwritten read data", bb.rd_data[0], '0);

    // Newer bank wins; same-cycle read sees the prior value.
    drive_idle();
    bb.wr[0] = 1'b1; bb.wr_addr[0] = AB'(3); bb.wr_data[0] = 64'hA7;
    cycle();
    drive_idle();
    cycle();
    drive_idle();
    bb.wr[2] = 1'b1; bb.wr_addr[2] = AB'(3); bb.wr_data[2] = 64'hB2;
    bb.rd = '1;
    for (int p = 0; p < NO; p++) bb.rd_addr[p] = AB'(3);
    cycle();
    for (int p = 0; p < NO; p++) chk($sformatf("read-before-write[%0d]", p), bb.rd_data[p], 64'hA7);
    drive_idle();
    bb.rd = '1;
    for (int p = 0; p < NO; p++) bb.rd_addr[p] = AB'(3);
    cycle();
    for (int p = 0; p < NO; p++) chk($sformatf("newest bank[%0d]", p), bb.rd_data[p], 64'hB2);

    // Same-address collision: highest port wins and the pulse is reported.
    drive_idle();
    bb.wr[1] = 1'b1; bb.wr_addr[1] = AB'(9); bb.wr_data[1] = 64'h11;
    bb.wr[3] = 1'b1; bb.wr_addr[3] = AB'(9); bb.wr_data[3] = 64'h33;
    cycle();
    chk("collision pulse", W'(bb.wr_collision), W'(1));
    drive_idle();
    bb.rd[0] = 1'b1; bb.rd_addr[0] = AB'(9);
    cycle();
    chk("collision winner", bb.rd_data[0], 64'h33);
    chk("collision cleared", W'(bb.wr_collision), '0);

    // Small instance: entry survives many timestamp wraps via demotion to STALE.
    drive_idle();
    bs.wr[1] = 1'b1; bs.wr_addr[1] = AS'(2); bs.wr_data[1] = 64'h55;
    cycle();
    drive_idle();
    repeat (200) cycle();
    bs.rd[0] = 1'b1; bs.rd_addr[0] = AS'(2);
    cycle();
    chk("wrap survivor", bs.rd_data[0], 64'h55);
    chk("entry(2,1) stale", W'(dut_s.r_state[2][1]), W'(STALE));
    chk("entry(2,0) invalid", W'(dut_s.r_state[2][0]), W'(INVALID));
    chk("entry(2,2) invalid", W'(dut_s.r_state[2][2]), W'(INVALID));
    chk("entry(2,3) invalid", W'(dut_s.r_state[2][3]), W'(INVALID));
    drive_idle();
    bs.wr[0] = 1'b1; bs.wr_addr[0] = AS'(2); bs.wr_data[0] = 64'h66;
    cycle();
    drive_idle();
    bs.rd[0] = 1'b1; bs.rd_addr[0] = AS'(2);
    cycle();
    chk("fresh beats stale", bs.rd_data[0], 64'h66);

    // Randomised traffic with idle gaps long enough for several small-instance wraps.
    for (int k = 0; k < 1200; k++) begin
      rand_inputs();
      cycle();
      if (k % 150 == 149) begin
        drive_idle();
        repeat (45) cycle();
      end
    end

    // Asynchronous reset with reads in flight and the scrubber mid-sweep.
    rand_inputs();
    bb.rd = '1;
    bs.rd = '1;
    cycle();
    #2;
    rst = 1'b1;
    #1;
    for (int p = 0; p < NO; p++) begin
      chk($sformatf("async rst big.rd_valid[%0d]", p), W'(bb.rd_valid[p]), '0);
      chk($sformatf("async rst small.rd_valid[%0d]", p), W'(bs.rd_valid[p]), '0);
      chk($sformatf("async rst big.rd_data[%0d]", p), bb.rd_data[p], '0);
    end
    chk("async rst big.ptr", W'(dut_b.r_ptr), '0);
    chk("async rst small.ptr", W'(dut_s.r_ptr), '0);
    model_reset();
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      bb.rd = '1;
      bs.rd = '1;
      for (int p = 0; p < NO; p++) begin
        bb.rd_addr[p] = AB'(a);
        bs.rd_addr[p] = AS'(a % DS);
      end
      cycle();
      if (a == 0) chk("small.ptr after release", W'(dut_s.r_ptr), W'(1));
      chk($sformatf("post-reset big read %0d", a), bb.rd_data[0], '0);
      chk($sformatf("post-reset small read %0d", a), bs.rd_data[0], '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
